// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write ports, read ports, busy scoreboard, init status.
// dbg_state mirrors the sequencer state (0 = clearing, 1 = running).
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic                     we0;
   logic [ADDR_W-1:0]        waddr0;
   logic [DATA_W-1:0]        wdata0;
   logic                     we1;
   logic [ADDR_W-1:0]        waddr1;
   logic [DATA_W-1:0]        wdata1;
   logic [NUM_RD-1:0]        re;
   logic [NUM_RD*ADDR_W-1:0] raddr;
   logic [NUM_RD*DATA_W-1:0] rdata;
   logic [NUM_RD-1:0]        rd_pending;
   logic                     busy_set;
   logic [ADDR_W-1:0]        busy_addr;
   logic                     init_done;
   logic                     dbg_state;

   modport master (
      output we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr, busy_set, busy_addr,
      input  rdata, rd_pending, init_done, dbg_state
   );

   modport slave (
      input  we0, waddr0, wdata0, we1, waddr1, wdata1, re, raddr, busy_set, busy_addr,
      output rdata, rd_pending, init_done, dbg_state
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NUM_RD bypassed read ports, per-entry busy
// scoreboard, and a post-reset sequencer that zeroes the array one entry per cycle.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input logic        clk,
   input logic        rst,
   regfile_mp_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [DEPTH-1:0]    busy_q, busy_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                     run;
   logic                     wr0_ok, wr1_ok, set_ok;
   logic [ADDR_W-1:0]        ra;
   logic                     hit0, hit1;
   logic [NUM_RD*DATA_W-1:0] rdata_c;
   logic [NUM_RD-1:0]        pend_c;

   assign run    = (state_q == ST_RUN);
   assign wr0_ok = run && bus.we0 && !(ZERO_REG != 0 && bus.waddr0 == '0);
   assign wr1_ok = run && bus.we1 && !(ZERO_REG != 0 && bus.waddr1 == '0);
   assign set_ok = run && bus.busy_set && !(ZERO_REG != 0 && bus.busy_addr == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         busy_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
      end
   end

   // Busy set is applied after the clears so a new producer wins over a retiring one.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      busy_d    = busy_q;
      case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == '1) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (wr0_ok) busy_d[bus.waddr0]    = 1'b0;
            if (wr1_ok) busy_d[bus.waddr1]    = 1'b0;
            if (set_ok) busy_d[bus.busy_addr] = 1'b1;
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   // Port 0 is written last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) begin
         mem_q[clr_cnt_q] <= '0;
      end else begin
         if (wr1_ok) mem_q[bus.waddr1] <= bus.wdata1;
         if (wr0_ok) mem_q[bus.waddr0] <= bus.wdata0;
      end
   end

   always_comb begin
      rdata_c = '0;
      pend_c  = '0;
      ra      = '0;
      hit0    = 1'b0;
      hit1    = 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
         ra   = bus.raddr[i*ADDR_W +: ADDR_W];
         hit0 = wr0_ok && (bus.waddr0 == ra);
         hit1 = wr1_ok && (bus.waddr1 == ra);
         if (run && bus.re[i] && !(ZERO_REG != 0 && ra == '0)) begin
            if (hit0)      rdata_c[i*DATA_W +: DATA_W] = bus.wdata0;
            else if (hit1) rdata_c[i*DATA_W +: DATA_W] = bus.wdata1;
            else           rdata_c[i*DATA_W +: DATA_W] = mem_q[ra];
            pend_c[i] = busy_q[ra] && !hit0 && !hit1;
         end
      end
   end

   assign bus.rdata      = rdata_c;
   assign bus.rd_pending = pend_c;
   assign bus.init_done  = run;
   assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear sequence, bypass, write collisions, scoreboard, zero register, reclear.
module tb_regfile_mp;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus();

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [DW-1:0] rd_data(input int p);
      return bus.rdata[p*DW +: DW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.we0       = 1'b0;
      bus.waddr0    = '0;
      bus.wdata0    = '0;
      bus.we1       = 1'b0;
      bus.waddr1    = '0;
      bus.wdata1    = '0;
      bus.re        = '0;
      bus.raddr     = '0;
      bus.busy_set  = 1'b0;
      bus.busy_addr = '0;
   endtask

   task automatic set_rd(input int p, input logic en, input logic [AW-1:0] a);
      bus.re[p]             = en;
      bus.raddr[p*AW +: AW] = a;
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (bus.init_done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      int n;
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      set_rd(0, 1'b1, 5'd5);
      set_rd(1, 1'b1, 5'd9);
      #1;
      checks++;
      if ({bus.init_done, bus.dbg_state, bus.rd_pending, bus.rdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got init=%b st=%b pend=%b rdata=%h required all 0",
                  bus.init_done, bus.dbg_state, bus.rd_pending, bus.rdata);
      end
      rst = 1'b0;
      wait_init(n);
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL init_latency: got %0d cycles required 32", n);
      end
      for (int a = 0; a < 32; a++) begin
         set_rd(0, 1'b1, AW'(a));
         set_rd(1, 1'b1, AW'(31 - a));
         #1;
         checks++;
         if (bus.rdata !== '0 || bus.rd_pending !== '0) begin
            errors++;
            $display("FAIL cleared_read a=%0d: got rdata=%h pend=%b required 0", a, bus.rdata, bus.rd_pending);
         end
      end
      idle_inputs();
   endtask

   task automatic test_write_bypass();
      tick();
      bus.we0    = 1'b1;
      bus.waddr0 = 5'd5;
      bus.wdata0 = 32'hDEAD_BEEF;
      set_rd(0, 1'b1, 5'd5);
      set_rd(1, 1'b1, 5'd6);
      #1;
      checks++;
      if (rd_data(0) !== 32'hDEAD_BEEF || rd_data(1) !== 32'h0) begin
         errors++;
         $display("FAIL bypass_we0: got %h/%h required deadbeef/00000000", rd_data(0), rd_data(1));
      end
      tick();
      bus.we0 = 1'b0;
      #1;
      checks++;
      if (rd_data(0) !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL array_read5: got %h required deadbeef", rd_data(0));
      end
      set_rd(0, 1'b0, 5'd5);
      #1;
      checks++;
      if (rd_data(0) !== 32'h0) begin
         errors++;
         $display("FAIL re_gate: got %h required 00000000", rd_data(0));
      end
      idle_inputs();
   endtask

   task automatic test_dual_write();
      tick();
      bus.we0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'h1;
      bus.we1 = 1'b1; bus.waddr1 = 5'd7; bus.wdata1 = 32'h2;
      set_rd(0, 1'b1, 5'd7);
      #1;
      checks++;
      if (rd_data(0) !== 32'h1) begin
         errors++;
         $display("FAIL collide_bypass: got %h required 00000001", rd_data(0));
      end
      tick();
      bus.we0 = 1'b0; bus.we1 = 1'b0;
      #1;
      checks++;
      if (rd_data(0) !== 32'h1) begin
         errors++;
         $display("FAIL collide_array: got %h required 00000001", rd_data(0));
      end
      bus.we0 = 1'b1; bus.waddr0 = 5'd10; bus.wdata0 = 32'hAAAA_0010;
      bus.we1 = 1'b1; bus.waddr1 = 5'd11; bus.wdata1 = 32'hBBBB_0011;
      set_rd(0, 1'b1, 5'd10);
      set_rd(1, 1'b1, 5'd11);
      #1;
      checks++;
      if (rd_data(0) !== 32'hAAAA_0010 || rd_data(1) !== 32'hBBBB_0011) begin
         errors++;
         $display("FAIL dual_bypass: got %h/%h required aaaa0010/bbbb0011", rd_data(0), rd_data(1));
      end
      tick();
      bus.we0 = 1'b0; bus.we1 = 1'b0;
      #1;
      checks++;
      if (rd_data(0) !== 32'hAAAA_0010 || rd_data(1) !== 32'hBBBB_0011) begin
         errors++;
         $display("FAIL dual_array: got %h/%h required aaaa0010/bbbb0011", rd_data(0), rd_data(1));
      end
      idle_inputs();
   endtask

   task automatic test_scoreboard();
      tick();
      bus.busy_set = 1'b1; bus.busy_addr = 5'd9;
      set_rd(0, 1'b1, 5'd9);
      set_rd(1, 1'b1, 5'd8);
      #1;
      checks++;
      if (bus.rd_pending !== 2'b00) begin
         errors++;
         $display("FAIL busy_before_edge: got %b required 00", bus.rd_pending);
      end
      tick();
      bus.busy_set = 1'b0;
      #1;
      checks++;
      if (bus.rd_pending !== 2'b01) begin
         errors++;
         $display("FAIL busy_set9: got %b required 01", bus.rd_pending);
      end
      set_rd(1, 1'b0, 5'd9);
      #1;
      checks++;
      if (bus.rd_pending !== 2'b01) begin
         errors++;
         $display("FAIL pend_re_gate: got %b required 01", bus.rd_pending);
      end
      set_rd(1, 1'b1, 5'd9);
      #1;
      checks++;
      if (bus.rd_pending !== 2'b11) begin
         errors++;
         $display("FAIL pend_both_ports: got %b required 11", bus.rd_pending);
      end
      bus.we1 = 1'b1; bus.waddr1 = 5'd9; bus.wdata1 = 32'h99;
      #1;
      checks++;
      if (bus.rd_pending !== 2'b00 || rd_data(0) !== 32'h99) begin
         errors++;
         $display("FAIL we1_resolves: got pend=%b data=%h required 00/00000099", bus.rd_pending, rd_data(0));
      end
      tick();
      bus.we1 = 1'b0;
      #1;
      checks++;
      if (bus.rd_pending !== 2'b00 || rd_data(1) !== 32'h99) begin
         errors++;
         $display("FAIL we1_cleared: got pend=%b data=%h required 00/00000099", bus.rd_pending, rd_data(1));
      end
      bus.busy_set = 1'b1; bus.busy_addr = 5'd9;
      bus.we0 = 1'b1; bus.waddr0 = 5'd9; bus.wdata0 = 32'h77;
      tick();
      bus.busy_set = 1'b0; bus.we0 = 1'b0;
      #1;
      checks++;
      if (bus.rd_pending !== 2'b11 || rd_data(0) !== 32'h77) begin
         errors++;
         $display("FAIL set_beats_clear: got pend=%b data=%h required 11/00000077", bus.rd_pending, rd_data(0));
      end
      bus.we0 = 1'b1; bus.waddr0 = 5'd9; bus.wdata0 = 32'h78;
      tick();
      bus.we0 = 1'b0;
      #1;
      checks++;
      if (bus.rd_pending !== 2'b00 || rd_data(0) !== 32'h78) begin
         errors++;
         $display("FAIL we0_clears: got pend=%b data=%h required 00/00000078", bus.rd_pending, rd_data(0));
      end
      idle_inputs();
   endtask

   task automatic test_zero_reg();
      tick();
      bus.we0 = 1'b1; bus.waddr0 = 5'd0; bus.wdata0 = 32'hFFFF_FFFF;
      bus.we1 = 1'b1; bus.waddr1 = 5'd0; bus.wdata1 = 32'hFFFF_FFFF;
      bus.busy_set = 1'b1; bus.busy_addr = 5'd0;
      set_rd(0, 1'b1, 5'd0);
      set_rd(1, 1'b1, 5'd0);
      #1;
      checks++;
      if (bus.rdata !== '0 || bus.rd_pending !== 2'b00) begin
         errors++;
         $display("FAIL zero_bypass: got rdata=%h pend=%b required 0/00", bus.rdata, bus.rd_pending);
      end
      tick();
      bus.we0 = 1'b0; bus.we1 = 1'b0; bus.busy_set = 1'b0;
      #1;
      checks++;
      if (bus.rdata !== '0 || bus.rd_pending !== 2'b00) begin
         errors++;
         $display("FAIL zero_after: got rdata=%h pend=%b required 0/00", bus.rdata, bus.rd_pending);
      end
      idle_inputs();
   endtask

   task automatic test_reclear();
      int n;
      tick();
      bus.we0 = 1'b1; bus.waddr0 = 5'd20; bus.wdata0 = 32'h1234;
      bus.busy_set = 1'b1; bus.busy_addr = 5'd21;
      tick();
      bus.we0 = 1'b0; bus.busy_set = 1'b0;
      set_rd(0, 1'b1, 5'd20);
      set_rd(1, 1'b1, 5'd21);
      #1;
      checks++;
      if (rd_data(0) !== 32'h1234 || bus.rd_pending !== 2'b10) begin
         errors++;
         $display("FAIL pre_reset_state: got data=%h pend=%b required 00001234/10", rd_data(0), bus.rd_pending);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.init_done !== 1'b0 || bus.rdata !== '0 || bus.rd_pending !== 2'b00) begin
         errors++;
         $display("FAIL async_reset_run: got init=%b rdata=%h pend=%b required 0/0/00",
                  bus.init_done, bus.rdata, bus.rd_pending);
      end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      bus.we0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h55;
      bus.busy_set = 1'b1; bus.busy_addr = 5'd3;
      set_rd(0, 1'b1, 5'd3);
      set_rd(1, 1'b1, 5'd21);
      #1;
      checks++;
      if (bus.init_done !== 1'b0 || bus.rdata !== '0 || bus.rd_pending !== 2'b00) begin
         errors++;
         $display("FAIL clear_outputs: got init=%b rdata=%h pend=%b required 0/0/00",
                  bus.init_done, bus.rdata, bus.rd_pending);
      end
      rst = 1'b1;
      #1;
      tick();
      rst = 1'b0;
      wait_init(n);
      checks++;
      if (n != 32) begin
         errors++;
         $display("FAIL reclear_latency: got %0d cycles required 32", n);
      end
      idle_inputs();
      set_rd(0, 1'b1, 5'd3);
      set_rd(1, 1'b1, 5'd20);
      #1;
      checks++;
      if (bus.rdata !== '0) begin
         errors++;
         $display("FAIL reclear_data: got %h required 0", bus.rdata);
      end
      bus.re = 2'b11;
      bus.raddr = {5'd21, 5'd3};
      #1;
      checks++;
      if (bus.rd_pending !== 2'b00) begin
         errors++;
         $display("FAIL reclear_busy: got %b required 00", bus.rd_pending);
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_write_bypass();
      test_dual_write();
      test_scoreboard();
      test_zero_reg();
      test_reclear();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
